// File: rtl/ift_sram_arb_pkg.sv
// Shared constants and types for the two-port taint-tracking SRAM arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ift_sram_arb_pkg;

   localparam int NumPorts = 2;

   typedef logic [0:0] port_id_t;

   // The port that is not p; used to alternate on a tie.
   function automatic port_id_t other_port(input port_id_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/ift_sram_arbiter_if.sv
// Port-side and SRAM-side bundle of the arbiter, each signal paired with its taint.
// Latency: n/a (wiring only).
// Backpressure: grant is the only flow control; an ungranted request retries next cycle.
interface ift_sram_arbiter_if #(
   parameter int Width = 32,
   parameter int Aw    = 15
);
   import ift_sram_arb_pkg::*;

   logic [NumPorts-1:0]            req_i,   req_i_taint;
   logic [NumPorts-1:0]            write_i, write_i_taint;
   logic [NumPorts-1:0][Aw-1:0]    addr_i,  addr_i_taint;
   logic [NumPorts-1:0][Width-1:0] wdata_i, wdata_i_taint;
   logic [NumPorts-1:0][Width-1:0] wmask_i, wmask_i_taint;

   logic [NumPorts-1:0]            gnt_o,    gnt_o_taint;
   logic [NumPorts-1:0]            rvalid_o, rvalid_o_taint;
   logic [Width-1:0]               rdata_o,  rdata_o_taint;

   logic                           sram_req_o,   sram_req_o_taint;
   logic                           sram_write_o, sram_write_o_taint;
   logic [Aw-1:0]                  sram_addr_o,  sram_addr_o_taint;
   logic [Width-1:0]               sram_wdata_o, sram_wdata_o_taint;
   logic [Width-1:0]               sram_wmask_o, sram_wmask_o_taint;
   logic [Width-1:0]               sram_rdata_i, sram_rdata_i_taint;

   // Requesters and SRAM model side.
   modport master (
      output req_i, req_i_taint, write_i, write_i_taint, addr_i, addr_i_taint,
             wdata_i, wdata_i_taint, wmask_i, wmask_i_taint,
             sram_rdata_i, sram_rdata_i_taint,
      input  gnt_o, gnt_o_taint, rvalid_o, rvalid_o_taint, rdata_o, rdata_o_taint,
             sram_req_o, sram_req_o_taint, sram_write_o, sram_write_o_taint,
             sram_addr_o, sram_addr_o_taint, sram_wdata_o, sram_wdata_o_taint,
             sram_wmask_o, sram_wmask_o_taint
   );

   // Arbiter side.
   modport slave (
      input  req_i, req_i_taint, write_i, write_i_taint, addr_i, addr_i_taint,
             wdata_i, wdata_i_taint, wmask_i, wmask_i_taint,
             sram_rdata_i, sram_rdata_i_taint,
      output gnt_o, gnt_o_taint, rvalid_o, rvalid_o_taint, rdata_o, rdata_o_taint,
             sram_req_o, sram_req_o_taint, sram_write_o, sram_write_o_taint,
             sram_addr_o, sram_addr_o_taint, sram_wdata_o, sram_wdata_o_taint,
             sram_wmask_o, sram_wmask_o_taint
   );

endinterface

// File: rtl/ift_rr_arb2.sv
// Two-way round-robin grant plus the taint of the selection decision itself.
// Latency: purely combinational, grant in the request cycle.
// Backpressure: the losing port of a tie is not granted and wins the next tie.
module ift_rr_arb2
   import ift_sram_arb_pkg::*;
(
   input  logic [NumPorts-1:0] req,
   input  logic [NumPorts-1:0] req_taint,
   input  port_id_t            last_q,
   input  logic                last_q_taint,
   output logic [NumPorts-1:0] gnt,
   output port_id_t            gnt_id,
   output logic                sel_t
);

   // Single requester wins outright; on a tie the port not granted last time wins.
   always_comb begin
      gnt    = '0;
      gnt_id = port_id_t'(0);
      if (&req) begin
         gnt_id = other_port(last_q);
      end else if (req[1]) begin
         gnt_id = port_id_t'(1);
      end
      if (|req) begin
         gnt[gnt_id] = 1'b1;
      end
   end

`ifdef IFT_SRAM_ARB_CONSERVATIVE_EN
   // Selection is tainted if either request is tainted or a tie is broken by tainted history.
   assign sel_t = (|req_taint) | ((&req) & last_q_taint);
`else
   // Selection taint disabled: taints follow only the data of the port actually chosen.
   logic sel_t_unused;
   assign sel_t_unused = ^{req_taint, last_q_taint};
   assign sel_t = 1'b0;
`endif

endmodule

// File: rtl/ift_sram_arbiter.sv
// Two-port SRAM arbiter with taint propagation; IFT_SRAM_ARB_CONSERVATIVE_EN enables selection taint.
// Latency: grant and SRAM command combinational; rvalid one cycle after a granted read.
// Backpressure: an ungranted port must hold its request; a new grant is possible every cycle.
module ift_sram_arbiter #(
   parameter int Width     = 32,
   parameter int Depth     = 1 << 15,
   parameter int NumTaints = 1
) (
   input logic               clk_i,
   input logic               rst_ni,
   ift_sram_arbiter_if.slave bus
);
   import ift_sram_arb_pkg::*;

   localparam int Aw = $clog2(Depth);

   if (NumTaints != 1) begin : g_num_taints_check
      $error("ift_sram_arbiter: only NumTaints == 1 is supported");
   end

   logic [NumPorts-1:0] gnt;
   port_id_t            gnt_id;
   logic                sel_t;
   logic                any_gnt;
   port_id_t            last_q;
   logic                last_q_taint;
   logic [NumPorts-1:0] rvalid_q;
   logic [NumPorts-1:0] rvalid_taint_q;

   logic                req_sp, write_sp;
   logic [Aw-1:0]       addr_sp;
   logic [Width-1:0]    wdata_sp, wmask_sp;

   ift_rr_arb2 u_arb (
      .req          (bus.req_i),
      .req_taint    (bus.req_i_taint),
      .last_q       (last_q),
      .last_q_taint (last_q_taint),
      .gnt          (gnt),
      .gnt_id       (gnt_id),
      .sel_t        (sel_t)
   );

   assign any_gnt         = |gnt;
   assign bus.gnt_o       = gnt;
   assign bus.gnt_o_taint = bus.req_i_taint | {NumPorts{sel_t}};
   assign bus.rvalid_o       = rvalid_q;
   assign bus.rvalid_o_taint = rvalid_taint_q;
   assign bus.rdata_o        = bus.sram_rdata_i;
   assign bus.rdata_o_taint  = bus.sram_rdata_i_taint;

   // A tainted selection leaks every bit where the two candidates differ or either is tainted.
   always_comb begin
      req_sp   = 1'b0;
      write_sp = 1'b0;
      addr_sp  = '0;
      wdata_sp = '0;
      wmask_sp = '0;
      if (sel_t) begin
         req_sp   = bus.req_i_taint[0]   | bus.req_i_taint[1]   | (bus.req_i[0]   ^ bus.req_i[1]);
         write_sp = bus.write_i_taint[0] | bus.write_i_taint[1] | (bus.write_i[0] ^ bus.write_i[1]);
         addr_sp  = bus.addr_i_taint[0]  | bus.addr_i_taint[1]  | (bus.addr_i[0]  ^ bus.addr_i[1]);
         wdata_sp = bus.wdata_i_taint[0] | bus.wdata_i_taint[1] | (bus.wdata_i[0] ^ bus.wdata_i[1]);
         wmask_sp = bus.wmask_i_taint[0] | bus.wmask_i_taint[1] | (bus.wmask_i[0] ^ bus.wmask_i[1]);
      end
   end

   // SRAM command follows the granted port; zero when nobody is granted.
   always_comb begin
      bus.sram_req_o         = |bus.req_i;
      bus.sram_write_o       = 1'b0;
      bus.sram_addr_o        = '0;
      bus.sram_wdata_o       = '0;
      bus.sram_wmask_o       = '0;
      bus.sram_req_o_taint   = req_sp;
      bus.sram_write_o_taint = write_sp;
      bus.sram_addr_o_taint  = addr_sp;
      bus.sram_wdata_o_taint = wdata_sp;
      bus.sram_wmask_o_taint = wmask_sp;
      if (any_gnt) begin
         bus.sram_write_o       = bus.write_i[gnt_id];
         bus.sram_addr_o        = bus.addr_i[gnt_id];
         bus.sram_wdata_o       = bus.wdata_i[gnt_id];
         bus.sram_wmask_o       = bus.wmask_i[gnt_id];
         bus.sram_req_o_taint   = req_sp   | bus.req_i_taint[gnt_id];
         bus.sram_write_o_taint = write_sp | bus.write_i_taint[gnt_id];
         bus.sram_addr_o_taint  = addr_sp  | bus.addr_i_taint[gnt_id];
         bus.sram_wdata_o_taint = wdata_sp | bus.wdata_i_taint[gnt_id];
         bus.sram_wmask_o_taint = wmask_sp | bus.wmask_i_taint[gnt_id];
      end
   end

   // Round-robin history and its taint; reset makes port 0 win the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q       <= port_id_t'(1);
         last_q_taint <= 1'b0;
      end else begin
         if (any_gnt) begin
            last_q <= gnt_id;
         end
         if (any_gnt || (|bus.req_i_taint)) begin
            last_q_taint <= sel_t;
         end
      end
   end

   // Read response strobe one cycle after a granted read; reset drops anything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q       <= '0;
         rvalid_taint_q <= '0;
      end else begin
         rvalid_q       <= gnt & ~bus.write_i;
         rvalid_taint_q <= bus.gnt_o_taint | (gnt & bus.write_i_taint);
      end
   end

endmodule

// File: doc/ift_sram_arbiter.md
IFT_SRAM_ARBITER -- requirements
Module: ift_sram_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, SRAM word width in bits.
REQ-002 SHALL have parameter Depth, default 1<<15, SRAM words; derived Aw = $clog2(Depth).
REQ-003 SHALL have parameter NumTaints, default 1, taint vectors per signal; only 1 supported, elaboration assertion otherwise.
REQ-004 SHALL have clk_i  in  1  single clock, all state rising-edge.
REQ-005 SHALL have rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have req_i / req_i_taint  in  [1:0]  per-port request and its taint.
REQ-007 SHALL have write_i / write_i_taint  in  [1:0]  per-port write enable and taint.
REQ-008 SHALL have addr_i / addr_i_taint  in  [1:0][Aw-1:0]  per-port word address and taint.
REQ-009 SHALL have wdata_i, wmask_i and their _taint  in  [1:0][Width-1:0]  per-port write data, bit mask, taints.
REQ-010 SHALL have gnt_o / gnt_o_taint  out  [1:0]  per-port grant, same cycle as request, and taint.
REQ-011 SHALL have rvalid_o / rvalid_o_taint  out  [1:0]  per-port read-data valid and taint.
REQ-012 SHALL have rdata_o / rdata_o_taint  out  [Width-1:0]  shared read data and taint.
REQ-013 SHALL have sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o and their _taint  out  SRAM-side command, widths as port side.
REQ-014 SHALL have sram_rdata_i / sram_rdata_i_taint  in  [Width-1:0]  SRAM read data (one cycle after request) and taint.

Function
REQ-015 SHALL grant combinationally: only one port requesting -> that port; both -> port != last_q; none -> no grant.
REQ-016 SHALL update last_q to the granted port on every grant; hold otherwise.
REQ-017 SHALL drive sram_req_o = |req_i and mux write/addr/wdata/wmask from the granted port; zero when idle.
REQ-018 SHALL, for a granted read (write_i=0), assert rvalid_o of that port exactly one cycle later for one cycle; writes produce no rvalid.
REQ-019 SHALL pass rdata_o = sram_rdata_i and rdata_o_taint = sram_rdata_i_taint unregistered.
REQ-020 SHALL accept a new grant every cycle; back-to-back reads from alternating ports yield rvalid on alternating ports.
REQ-021 SHALL compute selection taint sel_t = req_i_taint[0] | req_i_taint[1] | (req_i[0] & req_i[1] & last_q_taint).
REQ-022 SHALL drive gnt_o_taint[p] = req_i_taint[p] | sel_t.
REQ-023 SHALL drive sram_X_taint = muxed X_taint of granted port, ORed with (X0_taint | X1_taint | X0^X1) when sel_t.
REQ-024 SHALL register last_q_taint <= sel_t on any grant or when any req_i_taint is set.
REQ-025 SHALL register rvalid taint per port: rvalid_o_taint[p] <= gnt_o_taint[p] | (gnt_o[p] & write_i_taint[p]).

Reset
REQ-026 SHALL on rst_ni low asynchronously set last_q=1 (port 0 wins first tie), last_q_taint=0, rvalid_o=0, rvalid_o_taint=0.
REQ-027 SHALL drop any in-flight read on reset; no rvalid follows after release.

Configuration
REQ-028 SHALL honour macro IFT_SRAM_ARB_CONSERVATIVE_EN: defined -> sel_t per REQ-021; undefined -> sel_t forced 0, taints follow actual selection only.

Structure
REQ-029 SHALL place port-count constant (2) and port-id typedef in package ift_sram_arb_pkg.
REQ-030 SHALL implement arbitration in sub-module ift_rr_arb2 (req, last_q in; gnt, sel_t out); taint register logic stays in top.

Verification
REQ-031 SHALL test: after reset both ports read addr 0x10 -> gnt_o=01, next cycle gnt_o=10, rvalid_o=01 then 10.
REQ-032 SHALL test: port1 writes 0xDEADBEEF mask all-ones to 0x20 -> sram_write_o=1, sram_addr_o=0x20, no rvalid.
REQ-033 SHALL test: port0 req with req_i_taint[0]=1, port1 idle, macro defined -> gnt_o_taint=11, sram data taint = port0^port1 diff bits.
REQ-034 SHALL test: same as REQ-033 without macro -> gnt_o_taint=01, sram taints equal port0 taints.
REQ-035 SHALL test: rst_ni low for one cycle the cycle after a read grant -> rvalid_o stays 00.
REQ-036 SHALL test: sram_rdata_i_taint=0x0000FFFF with rvalid -> rdata_o_taint=0x0000FFFF same cycle.
